vga_trace_renderer: RTL and testbench

- Multi-channel, parametrised successor to the single-screen ECG/EMG VGA controller.
- Generates its own VGA timing from the system clock via a pixel-enable divider.
- Fetches per-column samples from the shared signal memory and draws CHANNELS stacked trace windows over a supplied background colour.
- Traces are continuous: each column draws a vertical span joining the previous and current sample. A per-frame scroll offset gives ring-buffer scrolling.

---
 rtl/vga_trace_renderer.sv | 146 ++++++++++++++
 tb/tb_vga_trace_renderer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_trace_renderer.sv
// vga_trace_renderer: self-timed VGA scanout drawing CHANNELS stacked, scrolling signal traces over a background
module vga_trace_renderer #(
    parameter int CLK_DIV = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int CHANNELS = 2,
    parameter int WIN_X0 = 55,
    parameter int WIN_W = 335,
    parameter int WIN_Y0 = 45,
    parameter int WIN_H = 180,
    parameter int WIN_GAP = 29,
    parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h559,
    parameter int CH_STRIDE = 340,
    parameter int SAMPLE_BITS = 12,
    parameter int SCALE_SHIFT = 4,
    parameter logic [12*CHANNELS-1:0] CH_COLORS = {12'hF00, 12'h0F0}
) (
    input  logic              clock,
    input  logic              reset,
    output logic              hSync,
    output logic              vSync,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic [ADDR_W-1:0] sig_addr,
    input  logic [31:0]       sig_data,
    input  logic [11:0]       bg_color,
    input  logic [ADDR_W-1:0] scroll_offset,
    output logic              frame_start,
    output logic [9:0]        x,
    output logic [9:0]        y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]  r_div;
    logic [9:0]        r_x, r_y, r_prev, r_cur, r_py, r_fetch_y0;
    logic              r_hsync, r_vsync, r_fs, r_pend;
    logic [11:0]       r_rgb;
    logic [ADDR_W-1:0] r_addr, r_scroll;

    logic              w_tick, w_line_hit, w_hit, w_fetch, w_lit, w_active, w_hs, w_vs, w_unused;
    logic [9:0]        w_line_y0, w_py, w_prev_n, w_cur_n, w_lo, w_hi;
    logic [11:0]       w_ch_color, w_rgb;
    logic [ADDR_W-1:0] w_ch_base, w_fetch_addr;
    int                w_col, w_h;

    assign w_tick = int'(r_div) == CLK_DIV - 1;
    assign w_hs = !(int'(r_x) >= H_ACTIVE + H_FP && int'(r_x) < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs = !(int'(r_y) >= V_ACTIVE + V_FP && int'(r_y) < V_ACTIVE + V_FP + V_SYNC);
    assign w_unused = ^sig_data[31:SAMPLE_BITS];

    // Windows never overlap vertically, so the current line selects at most one channel
    always_comb begin
        w_line_hit = 1'b0;
        w_line_y0 = '0;
        w_ch_color = '0;
        w_ch_base = BASE_ADDR;
        for (int k = 0; k < CHANNELS; k++)
            if (int'(r_y) >= WIN_Y0 + k*(WIN_H + WIN_GAP) && int'(r_y) < WIN_Y0 + k*(WIN_H + WIN_GAP) + WIN_H) begin
                w_line_hit = 1'b1;
                w_line_y0 = 10'(WIN_Y0 + k*(WIN_H + WIN_GAP));
                w_ch_color = CH_COLORS[12*k +: 12];
                w_ch_base = ADDR_W'(int'(BASE_ADDR) + k*CH_STRIDE);
            end
    end

    always_comb begin
        w_col = int'(r_x) + 1 - WIN_X0;
        w_fetch = w_line_hit && w_col >= 0 && w_col < WIN_W;
        w_col = w_col + int'(r_scroll);
        w_col = (w_col >= WIN_W) ? w_col - WIN_W : w_col;
        w_fetch_addr = w_ch_base + ADDR_W'(w_col);
        w_h = int'(sig_data[SAMPLE_BITS-1:0] >> SCALE_SHIFT);
        w_h = (w_h > WIN_H - 1) ? WIN_H - 1 : w_h;
        w_py = r_fetch_y0 + 10'(WIN_H - 1 - w_h);
    end

    // The span for this column is formed from the freshly captured sample, so the registered pixel matches x
    always_comb begin
        w_hit = w_line_hit && int'(r_x) >= WIN_X0 && int'(r_x) < WIN_X0 + WIN_W;
        w_cur_n = r_py;
        w_prev_n = (int'(r_x) == WIN_X0) ? r_py : r_cur;
        w_lo = (w_prev_n < w_cur_n) ? w_prev_n : w_cur_n;
        w_hi = (w_prev_n < w_cur_n) ? w_cur_n : w_prev_n;
        w_lit = w_hit && r_y >= w_lo && r_y <= w_hi;
        w_active = int'(r_x) < H_ACTIVE && int'(r_y) < V_ACTIVE;
        w_rgb = w_lit ? w_ch_color : (w_active ? bg_color : 12'h000);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
            r_x <= '0;
            r_y <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb <= '0;
            r_addr <= BASE_ADDR;
            r_fs <= 1'b0;
            r_pend <= 1'b0;
            r_prev <= '0;
            r_cur <= '0;
            r_py <= '0;
            r_fetch_y0 <= '0;
            r_scroll <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            r_fs <= w_tick && r_x == '0 && r_y == '0;
            r_pend <= w_tick && w_fetch;
            if (r_pend) r_py <= w_py;
            if (w_tick) begin
                r_x <= (int'(r_x) == H_TOTAL - 1) ? '0 : r_x + 10'd1;
                if (int'(r_x) == H_TOTAL - 1) r_y <= (int'(r_y) == V_TOTAL - 1) ? '0 : r_y + 10'd1;
                r_hsync <= w_hs;
                r_vsync <= w_vs;
                r_rgb <= w_rgb;
                if (r_x == '0 && r_y == '0) r_scroll <= (int'(scroll_offset) >= WIN_W) ? '0 : scroll_offset;
                if (w_fetch) begin
                    r_addr <= w_fetch_addr;
                    r_fetch_y0 <= w_line_y0;
                end
                if (w_hit) begin
                    r_prev <= w_prev_n;
                    r_cur <= w_cur_n;
                end
            end
        end
    end

    assign hSync = r_hsync;
    assign vSync = r_vsync;
    assign {VGA_R, VGA_G, VGA_B} = r_rgb;
    assign sig_addr = r_addr;
    assign frame_start = r_fs;
    assign x = r_x;
    assign y = r_y;
endmodule

// File: tb/tb_vga_trace_renderer.sv
// tb_vga_trace_renderer: directed frame checks on a reduced-geometry renderer plus sync timing of the default one
module tb_vga_trace_renderer;
    localparam int HT = 54;
    localparam int VT = 37;

    typedef struct {
        int s;
        int k;
        int px;
        int py;
        int e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic hs, vs, fs;
    logic [3:0] r, g, b;
    logic [11:0] addr, bg, scroll;
    logic [31:0] data;
    logic [9:0] x, y;
    int mode = 0;

    logic d_hs, d_unused_vs, d_unused_fs;
    logic [3:0] d_unused_r, d_unused_g, d_unused_b;
    logic [11:0] d_unused_addr;
    logic [9:0] d_unused_x, d_unused_y;

    function automatic logic [31:0] mem_rd(int m, logic [11:0] a);
        int n;
        n = (int'(a) - 'h559) % 25;
        if (n < 0) n = 0;
        return (m == 0) ? 32'hDEAD_0050 : (m == 2) ? 32'h1234_5FFF : (32'hABC0_0000 | 32'(n << 4));
    endfunction

    assign data = mem_rd(mode, addr);
    assign bg = {x[3:0], y[3:0], 4'h5};

    vga_trace_renderer #(
        .CLK_DIV(3), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CHANNELS(2), .WIN_X0(5), .WIN_W(20), .WIN_Y0(3), .WIN_H(10), .WIN_GAP(2),
        .ADDR_W(12), .BASE_ADDR(12'h559), .CH_STRIDE(25), .SAMPLE_BITS(12), .SCALE_SHIFT(4),
        .CH_COLORS({12'hF00, 12'h0F0})
    ) dut (
        .clock(clk), .reset(rst), .hSync(hs), .vSync(vs), .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .sig_addr(addr), .sig_data(data), .bg_color(bg), .scroll_offset(scroll),
        .frame_start(fs), .x(x), .y(y)
    );

    vga_trace_renderer d_dut (
        .clock(clk), .reset(rst), .hSync(d_hs), .vSync(d_unused_vs),
        .VGA_R(d_unused_r), .VGA_G(d_unused_g), .VGA_B(d_unused_b),
        .sig_addr(d_unused_addr), .sig_data(32'h0), .bg_color(12'h0), .scroll_offset(12'h0),
        .frame_start(d_unused_fs), .x(d_unused_x), .y(d_unused_y)
    );

    // Outputs lag x/y by one pixel, so each change of x/y exposes the previous pixel's outputs
    logic [11:0] rgb_at [VT][HT];
    logic [11:0] addr_at [VT][HT];
    logic hs_at [VT][HT];
    logic vs_at [VT][HT];
    int lx = 0, ly = 0;
    always @(negedge clk) begin
        if (rst) begin
            lx <= 0;
            ly <= 0;
        end else if (int'(x) != lx || int'(y) != ly) begin
            rgb_at[ly][lx] <= {r, g, b};
            addr_at[ly][lx] <= addr;
            hs_at[ly][lx] <= hs;
            vs_at[ly][lx] <= vs;
            lx <= int'(x);
            ly <= int'(y);
        end
    end

    int fcnt = 0, fper = 0, fwide = 0;
    logic fs_d = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            fcnt <= 0;
            fs_d <= 1'b0;
        end else begin
            fs_d <= fs;
            if (fs && fs_d) fwide <= fwide + 1;
            if (fs) begin
                fper <= fcnt + 1;
                fcnt <= 0;
            end else fcnt <= fcnt + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(string nm, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_line(int line);
        int n = 0;
        while (int'(y) != line && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_line", int'(y), line);
    endtask

    task automatic wait_fs();
        int n = 0;
        while (!fs && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_seen", int'(fs), 1);
    endtask

    vec_t vecs[$];
    function automatic void add(int s, int k, int px, int py, int e);
        vec_t v;
        v.s = s; v.k = k; v.px = px; v.py = py; v.e = e;
        vecs.push_back(v);
    endfunction

    string knm[4] = '{"rgb", "addr", "hsync", "vsync"};
    int smode[7] = '{0, 1, 2, 1, 1, 1, 1};
    int sscroll[7] = '{0, 0, 0, 10, 19, 20, 400};

    initial begin
        int n;
        // constant h=5: ch0 line 7 green, ch1 line 19 red
        add(0,0,5,7,'h0F0); add(0,0,24,7,'h0F0); add(0,0,25,7,'h975); add(0,0,4,7,'h475);
        add(0,0,10,6,'hA65); add(0,0,10,8,'hA85); add(0,0,10,19,'hF00); add(0,0,10,18,'hA25);
        add(0,0,45,7,'h000); add(0,0,10,31,'h000); add(0,1,4,7,'h559); add(0,1,4,19,'h572);
        add(0,2,43,0,1); add(0,2,44,0,0); add(0,2,49,0,0); add(0,2,50,0,1);
        add(0,3,0,31,1); add(0,3,0,32,0); add(0,3,0,33,0); add(0,3,0,34,1);
        // ramp h=n: first column one pixel, then two-pixel spans, clamped to the window top
        add(1,0,5,12,'h0F0); add(1,0,5,11,'h5B5); add(1,0,6,11,'h0F0); add(1,0,6,12,'h0F0);
        add(1,0,6,10,'h6A5); add(1,0,8,9,'h0F0); add(1,0,8,10,'h0F0); add(1,0,8,11,'h8B5);
        add(1,0,8,8,'h885); add(1,0,20,3,'h0F0); add(1,0,20,4,'h445); add(1,0,5,24,'hF00);
        add(2,0,10,3,'h0F0); add(2,0,10,2,'hA25); add(2,0,10,15,'hF00); add(2,0,10,14,'hAE5); add(2,0,10,4,'hA45);
        add(3,1,4,7,'h563); add(3,0,5,3,'h0F0); add(3,0,5,4,'h545); add(3,1,14,7,'h559);
        add(3,0,15,8,'h0F0); add(3,0,15,2,'hF25);
        add(4,1,4,7,'h56C); add(4,1,5,7,'h559); add(4,0,6,5,'h0F0); add(4,0,5,4,'h545);
        add(5,1,4,7,'h559); add(5,1,5,7,'h55A); add(5,0,5,12,'h0F0); add(5,0,5,11,'h5B5);
        add(6,1,4,7,'h559); add(6,1,5,19,'h573);

        mode = smode[0];
        scroll = 12'(sscroll[0]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0); chk("rst_y", int'(y), 0); chk("rst_rgb", int'({r, g, b}), 0);
        chk("rst_hsync", int'(hs), 1); chk("rst_vsync", int'(vs), 1);
        chk("rst_addr", int'(addr), 'h559); chk("rst_fs", int'(fs), 0);
        rst = 1'b0;

        for (int s = 0; s < 7; s++) begin
            if (s > 0) begin
                mode = smode[s];
                scroll = 12'(sscroll[s]);
                wait_fs();
            end
            wait_line(VT - 1);
            foreach (vecs[i]) if (vecs[i].s == s) begin
                int got;
                got = (vecs[i].k == 0) ? int'(rgb_at[vecs[i].py][vecs[i].px]) :
                      (vecs[i].k == 1) ? int'(addr_at[vecs[i].py][vecs[i].px]) :
                      (vecs[i].k == 2) ? int'(hs_at[vecs[i].py][vecs[i].px]) : int'(vs_at[vecs[i].py][vecs[i].px]);
                chk($sformatf("s%0d_%s(%0d,%0d)", s, knm[vecs[i].k], vecs[i].px, vecs[i].py), got, vecs[i].e);
            end
        end
        chk("frame_period_clks", fper, HT * VT * 3);
        chk("frame_start_width", fwide, 0);

        n = 0;
        while (!(x == 10'd30 && y == 10'd20) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_30_20", int'(x) * 1000 + int'(y), 30020);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_x", int'(x), 0); chk("mid_rst_y", int'(y), 0); chk("mid_rst_rgb", int'({r, g, b}), 0);
        chk("mid_rst_hsync", int'(hs), 1); chk("mid_rst_vsync", int'(vs), 1);
        chk("mid_rst_addr", int'(addr), 'h559); chk("mid_rst_fs", int'(fs), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Default geometry: 96-pixel sync pulse and 800-pixel line at 4 clocks per pixel
    initial begin
        int lo, hi, n;
        lo = 0; hi = 0; n = 0;
        @(negedge clk);
        while (rst && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (d_hs && n < 5000) begin
            @(negedge clk);
            n++;
        end
        while (!d_hs && lo < 5000) begin
            @(negedge clk);
            lo++;
        end
        while (d_hs && hi < 5000) begin
            @(negedge clk);
            hi++;
        end
        chk("default_hsync_low_clks", lo, 384);
        chk("default_line_clks", lo + hi, 3200);
    end
endmodule
